// File: rtl/char_scroller.sv
// char_scroller: scrolls a small character word across a row of
// active-low 7-segment digits. The start position is either picked
// directly (manual mode) or advanced by a clock divider (auto mode),
// with pause and single-step control. The word buffer is writable
// through a simple one-slot-per-cycle write port.
module char_scroller #(
    parameter int NUM_DISP = 4,
    parameter int WORD_LEN = 8,
    parameter int TICK_DIV = 50000000,
    localparam int PW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  mode,
    input  logic [PW-1:0]         sel,
    input  logic                  pause,
    input  logic                  step,
    input  logic                  load_en,
    input  logic [PW-1:0]         load_addr,
    input  logic [2:0]            load_char,
    output logic [7*NUM_DISP-1:0] hex_out,
    output logic [PW-1:0]         pos,
    output logic                  tick
);

    localparam int              DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [PW:0]     WL       = (PW + 1)'(WORD_LEN);
    localparam logic [PW-1:0]   POS_LAST = PW'(WORD_LEN - 1);

    // Segment patterns are g..a, active low.
    function automatic logic [6:0] seg_of(input logic [2:0] c);
        logic [6:0] s;
        case (c)
            3'd0:    s = 7'b0100001; // d
            3'd1:    s = 7'b0000110; // E
            3'd2:    s = 7'b1111001; // 1
            3'd3:    s = 7'b1111111; // blank
            3'd4:    s = 7'b1000000; // 0
            3'd5:    s = 7'b0001001; // H
            3'd6:    s = 7'b1000111; // L
            default: s = 7'b0001100; // P
        endcase
        return s;
    endfunction

    // Power-up word "dE1" followed by blanks.
    function automatic logic [2:0] default_char(input int idx);
        logic [2:0] c;
        case (idx)
            0:       c = 3'd0;
            1:       c = 3'd1;
            2:       c = 3'd2;
            default: c = 3'd3;
        endcase
        return c;
    endfunction

    logic [PW-1:0]          pos_q, pos_d;
    logic [DW-1:0]          div_q, div_d;
    logic                   tick_q, tick_d;
    logic                   step_q;
    logic                   mode_q;
    logic [2:0]             buf_q [WORD_LEN];
    logic [2:0]             buf_d [WORD_LEN];
    logic [7*NUM_DISP-1:0]  hex_q, hex_d;

    logic                   step_rise;
    logic                   mode_chg;
    logic                   sel_valid;
    logic [PW-1:0]          pos_inc;

    // Edge/transition detection and helper terms for the position logic.
    always_comb begin
        step_rise = step & ~step_q;
        mode_chg  = mode ^ mode_q;
        sel_valid = ({1'b0, sel} < WL);
        pos_inc   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    end

    // Position, divider and tick. A mode change only clears the divider;
    // manual mode keeps it parked at zero so auto mode starts a full period.
    always_comb begin
        pos_d  = pos_q;
        div_d  = div_q;
        tick_d = 1'b0;
        if (!mode) begin
            div_d = '0;
            if (sel_valid) begin
                pos_d = sel;
            end
        end else if (mode_chg) begin
            div_d = '0;
        end else if (pause) begin
            if (step_rise) begin
                pos_d = pos_inc;
            end
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
            pos_d  = pos_inc;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Word buffer write; addresses beyond the word simply match no slot.
    always_comb begin
        for (int i = 0; i < WORD_LEN; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (load_en) begin
            for (int i = 0; i < WORD_LEN; i++) begin
                if (load_addr == PW'(i)) begin
                    buf_d[i] = load_char;
                end
            end
        end
    end

    // Display from the registered position/buffer, leftmost digit first.
    // pos + j never exceeds 2*WORD_LEN-2, so one conditional subtract wraps it.
    always_comb begin
        logic [PW:0] slot;
        slot  = '0;
        hex_d = '1;
        for (int j = 0; j < NUM_DISP; j++) begin
            slot = {1'b0, pos_q} + (PW + 1)'(j);
            if (slot >= WL) begin
                slot = slot - WL;
            end
            hex_d[7*(NUM_DISP-1-j) +: 7] = seg_of(buf_q[slot[PW-1:0]]);
        end
    end

    // State registers with synchronous active-low reset. mode_q follows the
    // input during reset so leaving reset never looks like a mode change.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pos_q  <= '0;
            div_q  <= '0;
            tick_q <= 1'b0;
            step_q <= 1'b0;
            mode_q <= mode;
            hex_q  <= '1;
            for (int i = 0; i < WORD_LEN; i++) begin
                buf_q[i] <= default_char(i);
            end
        end else begin
            pos_q  <= pos_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            step_q <= step;
            mode_q <= mode;
            hex_q  <= hex_d;
            for (int i = 0; i < WORD_LEN; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign hex_out = hex_q;
    assign pos     = pos_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_char_scroller.sv
// Bench for char_scroller: two instances (8-slot and 5-slot words, divider 4)
// share one stimulus stream; expectations are queued before each edge and
// compared one time unit after it.
module tb_char_scroller;

    logic        Clock = 1'b0;
    logic        Resetn, mode, pause, step, load_en;
    logic [2:0]  sel, load_addr, load_char;
    logic [27:0] hex8, hex5;
    logic [2:0]  pos8, pos5;
    logic        tick8, tick5;

    always #5 Clock = ~Clock;

    char_scroller #(.NUM_DISP(4), .WORD_LEN(8), .TICK_DIV(4)) dut8 (
        .Clock(Clock), .Resetn(Resetn), .mode(mode), .sel(sel), .pause(pause),
        .step(step), .load_en(load_en), .load_addr(load_addr),
        .load_char(load_char), .hex_out(hex8), .pos(pos8), .tick(tick8)
    );

    char_scroller #(.NUM_DISP(4), .WORD_LEN(5), .TICK_DIV(4)) dut5 (
        .Clock(Clock), .Resetn(Resetn), .mode(mode), .sel(sel), .pause(pause),
        .step(step), .load_en(load_en), .load_addr(load_addr),
        .load_char(load_char), .hex_out(hex5), .pos(pos5), .tick(tick5)
    );

    localparam logic [6:0] S_D = 7'b0100001;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_B = 7'b1111111;
    localparam logic [6:0] S_H = 7'b0001001;
    localparam logic [6:0] S_P = 7'b0001100;
    localparam logic [27:0] WORD0 = {S_D, S_E, S_1, S_B};
    localparam logic [27:0] ALL1  = 28'hFFFFFFF;

    typedef struct {
        string       tag;
        int          sig;
        logic [27:0] exp;
    } exp_t;

    typedef logic [2:0] wbuf_t [8];

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    wbuf_t bm8, bm5;

    function automatic logic [6:0] seg(input logic [2:0] c);
        logic [6:0] table_s [8];
        table_s = '{7'b0100001, 7'b0000110, 7'b1111001, 7'b1111111,
                    7'b1000000, 7'b0001001, 7'b1000111, 7'b0001100};
        return table_s[c];
    endfunction

    function automatic logic [27:0] exp_hex(input int p, input int wl, input wbuf_t b);
        logic [27:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            r[7*(3-j) +: 7] = seg(b[(p + j) % wl]);
        end
        return r;
    endfunction

    task automatic set_default_bufs();
        for (int i = 0; i < 8; i++) begin
            bm8[i] = (i < 3) ? 3'(i) : 3'd3;
            bm5[i] = (i < 3) ? 3'(i) : 3'd3;
        end
    endtask

    task automatic push(input string tag, input int sig, input logic [27:0] e);
        exp_t x;
        x.tag = tag;
        x.sig = sig;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic exp_state(input string tag, input int p8, input int p5, input bit t);
        push({tag, ".pos8"}, 1, 28'(p8));
        push({tag, ".pos5"}, 4, 28'(p5));
        push({tag, ".tick8"}, 2, 28'(t));
        push({tag, ".tick5"}, 5, 28'(t));
    endtask

    task automatic exp_disp(input string tag, input int p8, input int p5);
        push({tag, ".hex8"}, 0, exp_hex(p8, 8, bm8));
        push({tag, ".hex5"}, 3, exp_hex(p5, 5, bm5));
    endtask

    task automatic drain();
        exp_t        e;
        logic [27:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                0:       obs = hex8;
                1:       obs = {25'd0, pos8};
                2:       obs = {27'd0, tick8};
                3:       obs = hex5;
                4:       obs = {25'd0, pos5};
                5:       obs = {27'd0, tick5};
                default: obs = 'x;
            endcase
            n_cmp++;
            assert (obs === e.exp) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        drain();
    endtask

    initial begin
        int n, p8, p5, q8, q5;
        bit s;

        Resetn = 1'b0; mode = 1'b0; sel = 3'd0; pause = 1'b0; step = 1'b0;
        load_en = 1'b0; load_addr = 3'd0; load_char = 3'd0;
        set_default_bufs();

        // Reset edge: segments dark, position and tick cleared.
        push("rst.hex8", 0, ALL1);
        push("rst.hex5", 3, ALL1);
        exp_state("rst", 0, 0, 1'b0);
        cyc();

        // Word appears on the first edge after release and stays.
        Resetn = 1'b1;
        push("first.hex8", 0, WORD0);
        push("first.hex5", 3, WORD0);
        exp_state("first", 0, 0, 1'b0);
        cyc();
        push("two_edges.hex8", 0, WORD0);
        push("two_edges.hex5", 3, WORD0);
        cyc();

        // Manual select; sel beyond the 5-slot word holds that instance.
        sel = 3'd3;
        exp_state("m_sel3", 3, 3, 1'b0); exp_disp("m_sel3", 0, 0); cyc();
        sel = 3'd6;
        exp_state("m_sel6", 6, 3, 1'b0); exp_disp("m_sel6", 3, 3); cyc();
        sel = 3'd2; step = 1'b1;
        exp_state("m_step_ign", 2, 2, 1'b0); exp_disp("m_step_ign", 6, 3); cyc();
        step = 1'b0; pause = 1'b1;
        exp_state("m_pause_ign", 2, 2, 1'b0); exp_disp("m_pause_ign", 2, 2); cyc();
        sel = 3'd0; pause = 1'b0; step = 1'b1;
        exp_state("m_sel0", 0, 0, 1'b0); exp_disp("m_sel0", 2, 2); cyc();

        // Enter auto mode: the transition edge clears the divider, no advance.
        step = 1'b0; mode = 1'b1;
        exp_state("a_enter", 0, 0, 1'b0); exp_disp("a_enter", 0, 0); cyc();

        // Free-running scroll; step toggles every cycle and must be ignored.
        for (int k = 1; k <= 40; k++) begin
            step = k[0];
            exp_state("auto", (k / 4) % 8, (k / 4) % 5, (k % 4) == 0);
            exp_disp("auto", ((k - 1) / 4) % 8, ((k - 1) / 4) % 5);
            if (k == 29) push("pos7_slots7012", 0, {S_B, S_D, S_E, S_1});
            if (k == 13) push("wl5_pos3_slots3401", 3, {S_B, S_B, S_D, S_E});
            cyc();
        end

        // Two more counting cycles leave the divider at 2.
        step = 1'b0;
        exp_state("auto41", 2, 0, 1'b0); exp_disp("auto41", 2, 0); cyc();
        exp_state("auto42", 2, 0, 1'b0); exp_disp("auto42", 2, 0); cyc();

        // Paused for 20 cycles with three step rising edges.
        pause = 1'b1;
        n = 0; q8 = 2; q5 = 0;
        for (int c = 0; c < 20; c++) begin
            s = (c == 2) || (c == 8) || (c == 14);
            step = s;
            if (s) n++;
            p8 = (2 + n) % 8;
            p5 = n % 5;
            exp_state("pause", p8, p5, 1'b0);
            exp_disp("pause", q8, q5);
            cyc();
            q8 = p8; q5 = p5;
        end

        // Release: divider resumes from 2, so the tick lands on the second edge.
        pause = 1'b0; step = 1'b0;
        exp_state("release1", 5, 3, 1'b0); exp_disp("release1", 5, 3); cyc();

        // Load slot 1 with H on the tick edge.
        load_en = 1'b1; load_addr = 3'd1; load_char = 3'd5;
        exp_state("rel_tick", 6, 4, 1'b1); exp_disp("rel_tick", 5, 3); cyc();
        bm8[1] = 3'd5; bm5[1] = 3'd5;

        // Next display uses the new position and the new buffer. Also write
        // P to slot 5, which only exists in the 8-slot word.
        load_addr = 3'd5; load_char = 3'd7;
        exp_state("after_tick", 6, 4, 1'b0);
        push("load_h.hex8", 0, {S_B, S_B, S_D, S_H});
        push("load_h.hex5", 3, {S_B, S_D, S_H, S_1});
        cyc();
        bm8[5] = 3'd7;

        // Manual sel=5: valid for 8 slots, equal to the 5-slot length (hold).
        load_en = 1'b0; mode = 1'b0; sel = 3'd5;
        exp_state("sel5", 5, 4, 1'b0); exp_disp("sel5", 6, 4); cyc();
        exp_state("sel5b", 5, 4, 1'b0);
        push("slot5_P.hex8", 0, {S_P, S_B, S_B, S_D});
        push("slot5_P.hex5", 3, exp_hex(4, 5, bm5));
        cyc();

        // Back to auto for a few cycles, then reset mid-scroll during a load.
        mode = 1'b1;
        exp_state("re_auto0", 5, 4, 1'b0); exp_disp("re_auto0", 5, 4); cyc();
        exp_state("re_auto1", 5, 4, 1'b0); exp_disp("re_auto1", 5, 4); cyc();
        exp_state("re_auto2", 5, 4, 1'b0); exp_disp("re_auto2", 5, 4); cyc();

        Resetn = 1'b0; load_en = 1'b1; load_addr = 3'd1; load_char = 3'd7; step = 1'b1;
        push("rst_mid.hex8", 0, ALL1);
        push("rst_mid.hex5", 3, ALL1);
        exp_state("rst_mid", 0, 0, 1'b0);
        cyc();

        Resetn = 1'b1; mode = 1'b0; sel = 3'd0; load_en = 1'b0; step = 1'b0;
        set_default_bufs();
        push("rst_word.hex8", 0, WORD0);
        push("rst_word.hex5", 3, WORD0);
        exp_state("rst_word", 0, 0, 1'b0);
        cyc();
        exp_state("rst_hold", 0, 0, 1'b0); exp_disp("rst_hold", 0, 0); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
